// File: rtl/cpu_controller.sv
// Instruction-sequencing controller for a simple load/store datapath.
// Holds the instruction register and walks a Moore FSM that emits the
// register-file, datapath-latch and ALU control strobes for each instruction.
module cpu_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [15:0] sximm8
);

  localparam int unsigned IR_W = 16;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU_OP,
    S_WRITE_REG
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IR_W-1:0] ir;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;
  logic       is_mov_imm;
  logic       is_mov_reg;
  logic       is_mvn;
  logic       is_alu;
  logic       is_cmp;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
  assign is_alu     = (opcode == 3'b101) && (op != 2'b11);
  assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  // Instruction register: only accepts a new word while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir <= '0;
    end else if (load && (state == S_WAIT)) begin
      ir <= in;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection and Moore output decode.
  always_comb begin
    state_next = state;
    w          = 1'b0;
    readnum    = 3'd0;
    writenum   = 3'd0;
    write      = 1'b0;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    vsel       = 2'b00;
    ALUop      = 2'b00;
    shift      = 2'b00;

    unique case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (is_mov_imm)                 state_next = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn)  state_next = S_GET_B;
        else if (is_alu)                state_next = S_GET_A;
        else                            state_next = S_WAIT;
      end
      S_WRITE_IMM: begin
        writenum   = rn;
        vsel       = 2'b10;
        write      = 1'b1;
        state_next = S_WAIT;
      end
      S_GET_A: begin
        readnum    = rn;
        loada      = 1'b1;
        state_next = S_GET_B;
      end
      S_GET_B: begin
        readnum    = rm;
        loadb      = 1'b1;
        state_next = S_ALU_OP;
      end
      S_ALU_OP: begin
        shift      = sh;
        bsel       = 1'b0;
        asel       = is_mov_reg || is_mvn;
        ALUop      = is_mov_reg ? 2'b00 : op;
        loadc      = !is_cmp;
        loads      = is_cmp;
        state_next = is_cmp ? S_WAIT : S_WRITE_REG;
      end
      S_WRITE_REG: begin
        writenum   = rd;
        vsel       = 2'b00;
        write      = 1'b1;
        state_next = S_WAIT;
      end
      default: begin
        state_next = S_WAIT;
      end
    endcase
  end

endmodule
